parking_occupancy_tracker: RTL and testbench
============================================

# parking_occupancy_tracker

Downstream of the entrance gate controller. Counts cars in the lot from the gate's per-car entry pulse and the exit-lane sensor, then drives occupancy, free-slot and full/empty flags plus a two-digit active-low 7-segment display of free slots. `lot_full` feeds back to the entrance controller, which uses it to hold the barrier.

## Interface
- `CAPACITY`, 20: number of slots, 1..99.
- `CNT_W`, 7: width of the count outputs; must hold `CAPACITY`.
- `DEBOUNCE_CYC`, 4: cycles the synchronised exit sensor must stay stable. Used only with `PARK_DEBOUNCE_EN`.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `car_in` in 1: one-cycle pulse from the entrance controller when an admitted car passes in. Synchronous to `clk`.
- `exit_sensor` in 1: raw asynchronous level from the exit-lane sensor; high while a car is present.
- `clr_err` in 1: synchronous clear of both sticky error flags.
- `occupancy` out `CNT_W`: cars currently in the lot.
- `free_slots` out `CNT_W`: `CAPACITY - occupancy`.
- `lot_full` out 1: high when `occupancy == CAPACITY`.
- `lot_empty` out 1: high when `occupancy == 0`.
- `overflow_err` out 1: sticky; `car_in` arrived while full.
- `underflow_err` out 1: sticky; exit event arrived while empty.
- `HEX_TENS`, `HEX_ONES` out 7: active-low segments, bit order gfedcba, showing `free_slots` in decimal.
- `disp_busy` out 1: high while a display conversion is in progress.

## Operation
- **Exit path**
  - `exit_sensor` goes through a 2-FF synchroniser.
  - A rising edge of the conditioned level produces a one-cycle internal `car_out` pulse.
- **Counter update** (registered):
  - `car_in` only, not full: +1.
  - `car_out` only, not empty: -1.
  - Both in the same cycle: count unchanged, no error.
  - `car_in` while full: count unchanged, `overflow_err` set.
  - `car_out` while empty: count unchanged, `underflow_err` set.
  - `clr_err` clears both error flags. If a new error occurs in the same cycle, setting wins.
- **Flags**: `free_slots`, `lot_full` and `lot_empty` are combinational from the `occupancy` register.
- **Display FSM**, states `D_IDLE`, `D_CONV`, `D_LOAD`:
  - `D_IDLE`: when the pending flag is set, latch `free_slots` into the remainder, set tens to 0, go to `D_CONV`.
  - `D_CONV`: if remainder ≥ 10, subtract 10 and increment tens, one step per cycle. Otherwise go to `D_LOAD`.
  - `D_LOAD`: register the segment codes for tens and remainder into the HEX outputs, return to `D_IDLE`.
  - The pending flag is set whenever `occupancy` changes and at reset release.
  - A change during `D_CONV` or `D_LOAD` re-sets the pending flag, so the next conversion shows the latest value; the HEX outputs are never torn.
  - `disp_busy` is high in `D_CONV` and `D_LOAD`.
- **Segment codes** 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - Tens digit 0 is blanked to 1111111.

## Timing
- **Reset values**: `occupancy` 0, `free_slots` `CAPACITY`, `lot_empty` 1, `lot_full` 0, both errors 0, HEX 1111111, `disp_busy` 0, FSM in `D_IDLE`, pending 1.
  - The display therefore shows `CAPACITY` within tens + 3 cycles after reset deasserts.
- **`car_in` to `occupancy`**: 1 cycle.
- **`exit_sensor` edge to `occupancy`**: 3 cycles without debounce; 3 + `DEBOUNCE_CYC` cycles with it.
- **`occupancy` change to HEX update**: 1 (to `D_CONV`) + tens steps + 1 (`D_LOAD`) + 1; at most 12 cycles for 99.
- **Minimum `car_in` spacing**: 1 cycle; back-to-back pulses are all counted.
- **Reset mid-conversion**: the conversion is abandoned and the reset values apply immediately (asynchronous).

## Configuration
- `PARK_DEBOUNCE_EN` defined:
  - After the synchroniser, the level must hold a new value for `DEBOUNCE_CYC` consecutive cycles before the debounced level changes.
  - A glitch shorter than that produces no `car_out`.
- `PARK_DEBOUNCE_EN` undefined:
  - The synchronised level feeds the edge detector directly; every rising edge counts.
  - `DEBOUNCE_CYC` is ignored.

## Structure
- **Shared package `parking_pkg`**:
  - Display-state enum.
  - The 7-bit segment constants: blank, digits 0..9, and the E / n / 5 / P glyphs used by the gate controller.
  - A `seg_decode(digit)` function.
- **Sub-module `exit_sensor_cond`**: synchroniser, optional debounce and rising-edge pulse.
  - Parameter: `DEBOUNCE_CYC`.
  - Ports: `clk`, `reset`, `raw`, `pulse`.

## Test plan
- Reset, no stimulus → `occupancy` 0, `lot_empty` 1; HEX_TENS 1111001, HEX_ONES 1000000 (shows "20") within 5 cycles of reset release.
- 20 `car_in` pulses back-to-back → `occupancy` 20, `lot_full` 1, HEX shows 1111111 / 1000000 ("0"). A 21st pulse → `overflow_err` 1, count stays 20.
- At `occupancy` 5, `car_in` and an exit edge land in the same cycle → count stays 5, no error flag.
- `PARK_DEBOUNCE_EN` build: 2-cycle high glitch on `exit_sensor` → no decrement. A 10-cycle high → exactly one decrement.
- An exit edge at `occupancy` 0 → `underflow_err` 1, count stays 0. `clr_err` pulse → flag returns to 0.
- At 19 free (tens steps in progress) `car_in` arrives → HEX settles to "18", never shows an intermediate mix. Reset asserted during `D_CONV` → HEX 1111111 immediately.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and segment constants for the parking lot occupancy tracker
// and the entrance gate controller.
package parking_pkg;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_CONV = 2'd1,
        D_LOAD = 2'd2
    } disp_state_e;

    // Active-low segments, bit order gfedcba.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_N     = 7'b0101011;
    localparam logic [6:0] SEG_S     = 7'b0010010;
    localparam logic [6:0] SEG_P     = 7'b0001100;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/exit_sensor_cond.sv
// Exit-lane sensor conditioning: 2-FF synchroniser, optional debounce
// (enabled by PARK_DEBOUNCE_EN) and a one-cycle rising-edge pulse.
module exit_sensor_cond #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYC must be at least 1");
    end

    logic sync1_q;
    logic sync2_q;
    logic level;
    logic level_prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value; blocking here would collapse the synchroniser chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            level_prev_q <= level;
        end
    end

`ifdef PARK_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEBOUNCE_CYC + 1);

    logic             deb_q;
    logic             deb_d;
    logic [DEB_W-1:0] deb_cnt_q;
    logic [DEB_W-1:0] deb_cnt_d;

    // The debounced level flips only after DEBOUNCE_CYC consecutive disagreeing samples.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DEB_W'(DEBOUNCE_CYC - 1)) begin
                deb_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign level = deb_q;
`else
    assign level = sync2_q;
`endif

    assign pulse = level & ~level_prev_q;

endmodule

// File: rtl/parking_occupancy_tracker.sv
// Lot occupancy counter with full/empty/error flags and a two-digit 7-segment
// free-slot display. Optional exit debounce via PARK_DEBOUNCE_EN.
module parking_occupancy_tracker
    import parking_pkg::*;
#(
    parameter int CAPACITY     = 20,
    parameter int CNT_W        = 7,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             car_in,
    input  logic             exit_sensor,
    input  logic             clr_err,
    output logic [CNT_W-1:0] occupancy,
    output logic [CNT_W-1:0] free_slots,
    output logic             lot_full,
    output logic             lot_empty,
    output logic             overflow_err,
    output logic             underflow_err,
    output logic [6:0]       HEX_TENS,
    output logic [6:0]       HEX_ONES,
    output logic             disp_busy
);

    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] TEN = CNT_W'(10);

    logic car_out;

    exit_sensor_cond #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_exit_cond (
        .clk  (clk),
        .reset(reset),
        .raw  (exit_sensor),
        .pulse(car_out)
    );

    logic [CNT_W-1:0] occ_q, occ_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             occ_change;

    assign free_slots = CAP - occ_q;
    assign lot_full   = (occ_q == CAP);
    assign lot_empty  = (occ_q == '0);

    // NOTE: every always_comb output gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        occ_d = occ_q;
        ovf_d = ovf_q && !clr_err;
        unf_d = unf_q && !clr_err;
        if (car_in && !car_out) begin
            if (lot_full) ovf_d = 1'b1;
            else          occ_d = occ_q + 1'b1;
        end else if (car_out && !car_in) begin
            if (lot_empty) unf_d = 1'b1;
            else           occ_d = occ_q - 1'b1;
        end
    end

    assign occ_change = (occ_d != occ_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            occ_q <= occ_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    disp_state_e      state_q, state_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [3:0]       tens_q, tens_d;
    logic [6:0]       hex_tens_q, hex_tens_d;
    logic [6:0]       hex_ones_q, hex_ones_d;

    // HEX registers change only in D_LOAD, so a half-finished conversion is never visible.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q || occ_change;
        rem_d      = rem_q;
        tens_d     = tens_q;
        hex_tens_d = hex_tens_q;
        hex_ones_d = hex_ones_q;
        case (state_q)
            D_IDLE: begin
                if (pending_q) begin
                    rem_d     = free_slots;
                    tens_d    = '0;
                    pending_d = occ_change;
                    state_d   = D_CONV;
                end
            end
            D_CONV: begin
                if (rem_q >= TEN) begin
                    rem_d  = rem_q - TEN;
                    tens_d = tens_q + 4'd1;
                end else begin
                    state_d = D_LOAD;
                end
            end
            D_LOAD: begin
                hex_tens_d = (tens_q == 4'd0) ? SEG_BLANK : seg_decode(tens_q);
                hex_ones_d = seg_decode(rem_q[3:0]);
                state_d    = D_IDLE;
            end
            default: state_d = D_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= D_IDLE;
            pending_q  <= 1'b1;
            rem_q      <= '0;
            tens_q     <= '0;
            hex_tens_q <= SEG_BLANK;
            hex_ones_q <= SEG_BLANK;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            rem_q      <= rem_d;
            tens_q     <= tens_d;
            hex_tens_q <= hex_tens_d;
            hex_ones_q <= hex_ones_d;
        end
    end

    assign occupancy     = occ_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;
    assign HEX_TENS      = hex_tens_q;
    assign HEX_ONES      = hex_ones_q;
    assign disp_busy     = (state_q != D_IDLE);

endmodule

// File: tb/tb_parking_occupancy_tracker.sv
// Self-checking bench: directed scenarios plus randomized traffic checked
// against an event-level model of the lot.
module tb_parking_occupancy_tracker;

    localparam int CAPACITY     = 20;
    localparam int CNT_W        = 7;
    localparam int DEBOUNCE_CYC = 4;
`ifdef PARK_DEBOUNCE_EN
    localparam int D = DEBOUNCE_CYC;
`else
    localparam int D = 0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             car_in = 1'b0;
    logic             exit_sensor = 1'b0;
    logic             clr_err = 1'b0;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W-1:0] free_slots;
    logic             lot_full;
    logic             lot_empty;
    logic             overflow_err;
    logic             underflow_err;
    logic [6:0]       HEX_TENS;
    logic [6:0]       HEX_ONES;
    logic             disp_busy;

    parking_occupancy_tracker #(
        .CAPACITY    (CAPACITY),
        .CNT_W       (CNT_W),
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .car_in       (car_in),
        .exit_sensor  (exit_sensor),
        .clr_err      (clr_err),
        .occupancy    (occupancy),
        .free_slots   (free_slots),
        .lot_full     (lot_full),
        .lot_empty    (lot_empty),
        .overflow_err (overflow_err),
        .underflow_err(underflow_err),
        .HEX_TENS     (HEX_TENS),
        .HEX_ONES     (HEX_ONES),
        .disp_busy    (disp_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Model: car count, sticky errors and the history of sampled sensor levels.
    int   m_occ;
    logic m_ovf;
    logic m_unf;
    logic hist [16];

    function automatic logic [13:0] disp_pair(input int v);
        logic [6:0] t;
        t = (v / 10 == 0) ? 7'b1111111 : seg_tbl[v / 10];
        return {t, seg_tbl[v % 10]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_occ = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        for (int i = 0; i < 16; i++) hist[i] = 1'b0;
    endtask

    // An exit rising edge sampled at edge k is counted at edge k+2+D.
    task automatic model_edge(input logic ci, input logic ex, input logic ce);
        logic co;
        logic new_ovf;
        logic new_unf;
        for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = ex;
        co      = hist[2+D] && !hist[3+D];
        new_ovf = 1'b0;
        new_unf = 1'b0;
        if (ci && !co) begin
            if (m_occ == CAPACITY) new_ovf = 1'b1;
            else                   m_occ++;
        end else if (co && !ci) begin
            if (m_occ == 0) new_unf = 1'b1;
            else            m_occ--;
        end
        m_ovf = (m_ovf && !ce) || new_ovf;
        m_unf = (m_unf && !ce) || new_unf;
    endtask

    task automatic tick(input logic ci, input logic ex, input logic ce);
        @(negedge clk);
        car_in      = ci;
        exit_sensor = ex;
        clr_err     = ce;
        @(posedge clk);
        if (!reset) model_edge(ci, ex, ce);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        car_in      = 1'b0;
        exit_sensor = 1'b0;
        clr_err     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_model(input string pfx);
        check({pfx, "_occ"}, 32'(occupancy), 32'(m_occ));
        check({pfx, "_free"}, 32'(free_slots), 32'(CAPACITY - m_occ));
        check({pfx, "_full"}, 32'(lot_full), 32'(m_occ == CAPACITY));
        check({pfx, "_empty"}, 32'(lot_empty), 32'(m_occ == 0));
        check({pfx, "_ovf"}, 32'(overflow_err), 32'(m_ovf));
        check({pfx, "_unf"}, 32'(underflow_err), 32'(m_unf));
    endtask

    initial begin
        logic ex_lvl;
        int   ex_hold;
        logic ok;
        int   exp_occ;

        // Reset values while reset is held.
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_occ", 32'(occupancy), 0);
        check("rst_free", 32'(free_slots), 32'(CAPACITY));
        check("rst_empty", 32'(lot_empty), 1);
        check("rst_full", 32'(lot_full), 0);
        check("rst_errs", {30'd0, overflow_err, underflow_err}, 0);
        check("rst_hex", {18'd0, HEX_TENS, HEX_ONES}, 32'h3FFF);
        check("rst_busy", 32'(disp_busy), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) tick(1'b0, 1'b0, 1'b0);
        check("boot_hex20", {18'd0, HEX_TENS, HEX_ONES}, 32'(disp_pair(20)));

        // Fill the lot back-to-back, then one car too many.
        repeat (20) tick(1'b1, 1'b0, 1'b0);
        check("fill_occ", 32'(occupancy), 20);
        check("fill_full", 32'(lot_full), 1);
        check("fill_free", 32'(free_slots), 0);
        repeat (5) tick(1'b0, 1'b0, 1'b0);
        check("fill_hex0", {18'd0, HEX_TENS, HEX_ONES}, {18'd0, 7'b1111111, 7'b1000000});
        tick(1'b1, 1'b0, 1'b0);
        check("ovf_occ", 32'(occupancy), 20);
        check("ovf_flag", 32'(overflow_err), 1);

        // Exit while empty.
        do_reset();
        repeat (10) tick(1'b0, 1'b1, 1'b0);
        repeat (8) tick(1'b0, 1'b0, 1'b0);
        check("unf_occ", 32'(occupancy), 0);
        check("unf_flag", 32'(underflow_err), 1);
        tick(1'b0, 1'b0, 1'b1);
        check("unf_clr", 32'(underflow_err), 0);

        // car_in and car_out in the same cycle at occupancy 5.
        repeat (5) tick(1'b1, 1'b0, 1'b0);
        check("five_occ", 32'(occupancy), 5);
        tick(1'b0, 1'b1, 1'b0);
        repeat (D + 1) tick(1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        check("both_occ", 32'(occupancy), 5);
        repeat (3) tick(1'b0, 1'b1, 1'b0);
        repeat (10) tick(1'b0, 1'b0, 1'b0);
        check("both_occ_late", 32'(occupancy), 5);
        check("both_noerr", {30'd0, overflow_err, underflow_err}, 0);

        // Short glitch: ignored with debounce, counted without.
        repeat (2) tick(1'b0, 1'b1, 1'b0);
        repeat (10) tick(1'b0, 1'b0, 1'b0);
`ifdef PARK_DEBOUNCE_EN
        exp_occ = 5;
`else
        exp_occ = 4;
`endif
        check("glitch_occ", 32'(occupancy), 32'(exp_occ));
        repeat (10) tick(1'b0, 1'b1, 1'b0);
        repeat (10) tick(1'b0, 1'b0, 1'b0);
        check("long_exit_occ", 32'(occupancy), 32'(exp_occ - 1));

        // A change during conversion: display never shows a torn value.
        do_reset();
        repeat (6) tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        ok = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            if ({HEX_TENS, HEX_ONES} != disp_pair(20) && {HEX_TENS, HEX_ONES} != disp_pair(19) &&
                {HEX_TENS, HEX_ONES} != disp_pair(18)) ok = 1'b0;
        end
        check("no_tear", 32'(ok), 1);
        check("settle_18", {18'd0, HEX_TENS, HEX_ONES}, 32'(disp_pair(18)));

        // Reset during D_CONV.
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("mid_busy", 32'(disp_busy), 1);
        reset = 1'b1;
        model_reset();
        #1;
        check("midrst_hex", {18'd0, HEX_TENS, HEX_ONES}, 32'h3FFF);
        check("midrst_busy", 32'(disp_busy), 0);
        check("midrst_occ", 32'(occupancy), 0);
        @(negedge clk);
        reset = 1'b0;

        // Random traffic against the model; alternate fill-heavy and drain-heavy rounds.
        ex_lvl  = 1'b0;
        ex_hold = 6;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 150; i++) begin
                if (ex_hold == 0) begin
                    ex_lvl  = ~ex_lvl;
                    ex_hold = $urandom_range(6, 12);
                end
                ex_hold--;
                tick(($urandom_range(0, 99) < ((r % 2 == 0) ? 70 : 25)), ex_lvl,
                     ($urandom_range(0, 49) == 0));
                check_model("rnd");
            end
            ex_lvl  = 1'b0;
            ex_hold = 6;
            repeat (25) tick(1'b0, 1'b0, 1'b0);
            check_model("idle");
            check("rnd_hex", {18'd0, HEX_TENS, HEX_ONES}, 32'(disp_pair(CAPACITY - m_occ)));
            check("rnd_busy", 32'(disp_busy), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
